// File: rtl/router_rr_arbiter.sv
// Four-port round-robin input arbiter with burst hold, feeding a credit-tracked FIFO.
// One accept per cycle; the accepted word is registered onto the FIFO write port.
module router_rr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int CREDITS   = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req_i,
  input  logic [DATA_W-1:0] data_n_i,
  input  logic [DATA_W-1:0] data_s_i,
  input  logic [DATA_W-1:0] data_e_i,
  input  logic [DATA_W-1:0] data_w_i,
  output logic [3:0]        gnt_o,
  input  logic              credit_i,
  output logic              fifo_push_o,
  output logic [DATA_W-1:0] fifo_data_o,
  output logic [1:0]        fifo_src_o,
  output logic              stall_o,
  output logic              err_o
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

  state_t       state;
  logic [1:0]   last_ptr, owner;
  logic [BW-1:0] beats;
  logic [CW-1:0] credits;

  logic [1:0]   rr_win, win, idx;
  logic         rr_found, accept, has_credit, owner_go;
  logic [DATA_W-1:0] win_data;

  assign has_credit = (credits != '0);
  assign owner_go   = req_i[owner] && (beats < BURST_MAX);

  // First requester after last_ptr, wrapping around all four ports.
  always_comb begin
    rr_win   = last_ptr;
    rr_found = 1'b0;
    idx      = last_ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = last_ptr + 2'(k);
      if (!rr_found && req_i[idx]) begin
        rr_win   = idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    accept = 1'b0;
    win    = owner;
    case (state)
      IDLE: begin
        accept = rr_found && has_credit;
        win    = rr_win;
      end
      BURST:   accept = owner_go && has_credit;
      default: accept = 1'b0;
    endcase
    // Keep grants quiet while reset is held.
    accept = accept && rst_n;
  end

  assign gnt_o   = accept ? (4'b0001 << win) : 4'b0000;
  assign stall_o = !has_credit;

  always_comb begin
    case (win)
      2'd0:    win_data = data_n_i;
      2'd1:    win_data = data_s_i;
      2'd2:    win_data = data_e_i;
      default: win_data = data_w_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_ptr    <= 2'd3;
      owner       <= 2'd0;
      beats       <= '0;
      credits     <= CRED_MAX;
      fifo_push_o <= 1'b0;
      fifo_data_o <= '0;
      fifo_src_o  <= 2'd0;
      err_o       <= 1'b0;
    end else begin
      fifo_push_o <= accept;
      if (accept) begin
        fifo_data_o <= win_data;
        fifo_src_o  <= win;
      end

      if (accept && !credit_i)
        credits <= credits - 1'b1;
      else if (credit_i && !accept) begin
        if (credits == CRED_MAX) err_o <= 1'b1;
        else                     credits <= credits + 1'b1;
      end

      case (state)
        IDLE: if (accept) begin
          owner    <= rr_win;
          last_ptr <= rr_win;
          beats    <= BW'(1);
          state    <= BURST;
        end
        BURST: begin
          if (accept)           beats <= beats + 1'b1;
          else if (!has_credit) state <= STALL;
          else                  state <= IDLE;
        end
        STALL: if (has_credit) state <= owner_go ? BURST : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_rr_arbiter.sv
// Directed bench for router_rr_arbiter: cycle tables for rotation/bubble order,
// hand sequences for credit exhaustion, credit overflow and mid-burst reset.
module tb_router_rr_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0;
  logic          credit = 1'b0;
  logic [DW-1:0] dn = 32'h1111_1111, ds = 32'h2222_2222, de = 32'h3333_3333, dw = 32'h4444_4444;
  logic [3:0]    gnt;
  logic          push, stall, err;
  logic [DW-1:0] fdata;
  logic [1:0]    fsrc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_rr_arbiter #(.DATA_W(DW), .CREDITS(64), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .data_n_i(dn), .data_s_i(ds), .data_e_i(de), .data_w_i(dw),
    .gnt_o(gnt), .credit_i(credit),
    .fifo_push_o(push), .fifo_data_o(fdata), .fifo_src_o(fsrc),
    .stall_o(stall), .err_o(err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       credit;
    logic [3:0] gnt;
    logic       push;
    logic [1:0] src;
    logic       stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic cr, input logic [3:0] g,
                     input logic p, input logic [1:0] s, input logic st);
    vec_t v;
    v.rst = r; v.req = rq; v.credit = cr; v.gnt = g; v.push = p; v.src = s; v.stall = st;
    vecs.push_back(v);
  endtask

  function automatic logic [DW-1:0] port_data(input logic [1:0] s);
    case (s)
      2'd0:    return 32'h1111_1111;
      2'd1:    return 32'h2222_2222;
      2'd2:    return 32'h3333_3333;
      default: return 32'h4444_4444;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = 4'b0; credit = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Holds req_i until stall or a cycle budget; returns accepts and push/gnt-follow errors.
  task automatic drain(input logic [3:0] rq, input int budget, output int n_acc, output int n_bad);
    logic [3:0] prev;
    prev = 4'b0; n_acc = 0; n_bad = 0;
    req = rq;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (push !== (prev != 4'b0)) n_bad++;
      if (gnt != 4'b0) begin
        n_acc++;
        if (gnt !== rq) n_bad++;
      end
      prev = gnt;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n_acc, n_bad;
    string nm;

    // T1: all four requesting -> 4 beats each, one bubble between owners.
    add(1, 4'hF, 0, 4'h0, 0, 0, 0);
    add(0, 4'hF, 0, 4'h1, 0, 0, 0);
    add(0, 4'hF, 0, 4'h1, 1, 0, 0);
    add(0, 4'hF, 0, 4'h1, 1, 0, 0);
    add(0, 4'hF, 0, 4'h1, 1, 0, 0);
    add(0, 4'hF, 0, 4'h0, 1, 0, 0);
    add(0, 4'hF, 0, 4'h2, 0, 0, 0);
    add(0, 4'hF, 0, 4'h2, 1, 1, 0);
    add(0, 4'hF, 0, 4'h2, 1, 1, 0);
    add(0, 4'hF, 0, 4'h2, 1, 1, 0);
    add(0, 4'hF, 0, 4'h0, 1, 1, 0);
    add(0, 4'hF, 0, 4'h4, 0, 0, 0);
    add(0, 4'hF, 0, 4'h4, 1, 2, 0);
    add(0, 4'hF, 0, 4'h4, 1, 2, 0);
    add(0, 4'hF, 0, 4'h4, 1, 2, 0);
    add(0, 4'hF, 0, 4'h0, 1, 2, 0);
    add(0, 4'hF, 0, 4'h8, 0, 0, 0);
    add(0, 4'hF, 0, 4'h8, 1, 3, 0);
    add(0, 4'hF, 0, 4'h8, 1, 3, 0);
    add(0, 4'hF, 0, 4'h8, 1, 3, 0);
    add(0, 4'hF, 0, 4'h0, 1, 3, 0);
    add(0, 4'hF, 0, 4'h1, 0, 0, 0);
    // T5: N drops after 2 beats with S,W waiting -> bubble, S burst, bubble, W.
    add(1, 4'hB, 0, 4'h0, 0, 0, 0);
    add(0, 4'hB, 0, 4'h1, 0, 0, 0);
    add(0, 4'hB, 0, 4'h1, 1, 0, 0);
    add(0, 4'hA, 0, 4'h0, 1, 0, 0);
    add(0, 4'hA, 0, 4'h2, 0, 0, 0);
    add(0, 4'hA, 0, 4'h2, 1, 1, 0);
    add(0, 4'hA, 0, 4'h2, 1, 1, 0);
    add(0, 4'hA, 0, 4'h2, 1, 1, 0);
    add(0, 4'hA, 0, 4'h0, 1, 1, 0);
    add(0, 4'hA, 0, 4'h8, 0, 0, 0);
    add(0, 4'hA, 0, 4'h8, 1, 3, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      if (vecs[i].rst) rst_n = 1'b0;
      req = vecs[i].req;
      credit = vecs[i].credit;
      @(negedge clk);
      nm = $sformatf("vec%0d", i);
      check({nm, ".gnt"}, 32'(gnt), 32'(vecs[i].gnt));
      check({nm, ".push"}, 32'(push), 32'(vecs[i].push));
      check({nm, ".stall"}, 32'(stall), 32'(vecs[i].stall));
      if (vecs[i].rst) check({nm, ".err_rst"}, 32'(err), 32'd0);
      if (vecs[i].push) begin
        check({nm, ".src"}, 32'(fsrc), 32'(vecs[i].src));
        check({nm, ".data"}, fdata, port_data(vecs[i].src));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    // T4: credit at full credits -> err sticky, credits stay 64.
    do_reset();
    credit = 1'b1;
    @(negedge clk);
    check("t4.err_before", 32'(err), 32'd0);
    @(posedge clk); #1;
    credit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4.err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;

    // T2: E only, no credit return -> exactly 64 accepts, then stalled.
    drain(4'b0100, 110, n_acc, n_bad);
    check("t2.accepts", 32'(n_acc), 32'd64);
    check("t2.follow", 32'(n_bad), 32'd0);
    @(negedge clk);
    check("t2.stall", 32'(stall), 32'd1);
    check("t2.gnt_stalled", 32'(gnt), 32'd0);
    check("t4.err_still", 32'(err), 32'd1);
    @(posedge clk); #1;

    // T3: one credit pulse -> unstall next cycle, exactly one more E accept.
    credit = 1'b1;
    @(negedge clk);
    check("t3.same_cycle_stall", 32'(stall), 32'd1);
    check("t3.same_cycle_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    credit = 1'b0;
    @(negedge clk);
    check("t3.unstall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    drain(4'b0100, 12, n_acc, n_bad);
    check("t3.accepts", 32'(n_acc), 32'd1);
    @(negedge clk);
    check("t3.restall", 32'(stall), 32'd1);
    @(posedge clk); #1;

    // T6a: credit -> credits=1; then accept with same-cycle credit keeps 1.
    credit = 1'b1;
    @(posedge clk); #1;
    credit = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 10 && n_acc == 0; c++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        n_acc = 1;
        credit = 1'b1;
      end
      @(posedge clk); #1;
    end
    credit = 1'b0;
    check("t6.accept_seen", 32'(n_acc), 32'd1);
    @(negedge clk);
    check("t6.no_stall", 32'(stall), 32'd0);
    check("t6.burst_cont", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6.stall_after", 32'(stall), 32'd1);
    @(posedge clk); #1;

    // T6b: async reset mid-burst drops the in-flight push and restores credits.
    do_reset();
    req = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6.push_pre", 32'(push), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6.push_rst", 32'(push), 32'd0);
    check("t6.gnt_rst", 32'(gnt), 32'd0);
    check("t6.stall_rst", 32'(stall), 32'd0);
    check("t6.err_rst", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain(4'b0100, 110, n_acc, n_bad);
    check("t6.credits_full", 32'(n_acc), 32'd64);
    check("t6.follow", 32'(n_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
